// File: rtl/sat_pkg.sv
// Shared helpers for the signed saturating datapath.
//   sat_max(width) : largest two's complement value representable in width bits
//   sat_min(width) : smallest two's complement value representable in width bits
//   sext(value, from_w, to_w) : sign-extend the low from_w bits of value to to_w
//                               bits; bits at or above to_w are returned as zero
package sat_pkg;

   function automatic int sat_max(input int width);
      return (1 << (width - 1)) - 1;
   endfunction

   function automatic int sat_min(input int width);
      return -(1 << (width - 1));
   endfunction

   function automatic logic [31:0] sext(input logic [31:0] value,
                                        input int          from_w,
                                        input int          to_w);
      logic signed [31:0] t;
      // Park the field's sign bit at bit 31, then shift back arithmetically.
      t = value << (32 - from_w);
      t = t >>> (32 - from_w);
      if (to_w < 32) begin
         t = t & ~(32'sh1 << to_w) + 32'sh0 & ((32'sh1 << to_w) - 32'sh1);
      end
      return t;
   endfunction

endpackage

// File: rtl/signed_sat_adder.sv
// Combinational N-bit two's complement adder with saturation.
// Ports:
//   a, b : N-bit signed operands
//   sum  : a + b, clamped to the N-bit signed range on overflow
//   ovf  : 1 when the true sum did not fit and sum was clamped
module signed_sat_adder #(
   parameter int N = 6
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] sum,
   output logic         ovf
);
   import sat_pkg::*;

   localparam logic [N-1:0] SAT_HI = N'(sat_max(N));
   localparam logic [N-1:0] SAT_LO = N'(sat_min(N));

   logic [N:0] full;
   logic       c_into_msb;
   logic       c_out_msb;

   always_comb begin
      full       = {1'b0, a} + {1'b0, b};
      c_out_msb  = full[N];
      // The MSB sum bit is a ^ b ^ carry-in, so the carry-in falls out directly.
      c_into_msb = a[N-1] ^ b[N-1] ^ full[N-1];
      ovf        = c_into_msb ^ c_out_msb;
      // When overflow happens both operands share a sign; carry-out set means
      // both were negative.
      if (ovf) begin
         sum = c_out_msb ? SAT_LO : SAT_HI;
      end else begin
         sum = full[N-1:0];
      end
   end

endmodule

// File: rtl/signed_sat_accumulator.sv
// Streaming frame accumulator: sums signed W-bit samples of each frame with
// saturation at ACC_W bits and emits one result per frame through a one-entry
// output register.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   up_valid/up_ready     : sample handshake; up_ready = !down_valid | down_ready
//   up_data, up_last      : signed sample, end-of-frame marker
//   down_valid/down_ready : result handshake
//   down_data             : saturated signed frame sum
//   down_sat              : saturation occurred at least once in the frame
// ACC_W must be >= W.
module signed_sat_accumulator #(
   parameter int W     = 4,
   parameter int ACC_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             up_valid,
   output logic             up_ready,
   input  logic [W-1:0]     up_data,
   input  logic             up_last,
   output logic             down_valid,
   input  logic             down_ready,
   output logic [ACC_W-1:0] down_data,
   output logic             down_sat
);
   import sat_pkg::*;

   logic [ACC_W-1:0] acc_q,        acc_d;
   logic             sat_sticky_q, sat_sticky_d;
   logic             down_valid_q, down_valid_d;
   logic [ACC_W-1:0] down_data_q,  down_data_d;
   logic             down_sat_q,   down_sat_d;

   logic [ACC_W-1:0] sample_ext;
   logic [ACC_W-1:0] next_sum;
   logic             next_ovf;
   logic             up_fire;

   assign sample_ext = ACC_W'(sext(32'(up_data), W, ACC_W));

   signed_sat_adder #(.N(ACC_W)) u_adder (
      .a   (acc_q),
      .b   (sample_ext),
      .sum (next_sum),
      .ovf (next_ovf)
   );

   assign up_ready = !down_valid_q || down_ready;
   assign up_fire  = up_valid && up_ready;

   always_comb begin
      acc_d        = acc_q;
      sat_sticky_d = sat_sticky_q;
      down_valid_d = down_valid_q;
      down_data_d  = down_data_q;
      down_sat_d   = down_sat_q;

      if (down_valid_q && down_ready) begin
         down_valid_d = 1'b0;
      end

      // A last sample landing in the same cycle as an output accept overrides
      // the clear above, so back-to-back results have no bubble.
      if (up_fire) begin
         if (up_last) begin
            down_data_d  = next_sum;
            down_sat_d   = sat_sticky_q | next_ovf;
            down_valid_d = 1'b1;
            acc_d        = '0;
            sat_sticky_d = 1'b0;
         end else begin
            acc_d        = next_sum;
            sat_sticky_d = sat_sticky_q | next_ovf;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q        <= '0;
         sat_sticky_q <= 1'b0;
         down_valid_q <= 1'b0;
         down_data_q  <= '0;
         down_sat_q   <= 1'b0;
      end else begin
         acc_q        <= acc_d;
         sat_sticky_q <= sat_sticky_d;
         down_valid_q <= down_valid_d;
         down_data_q  <= down_data_d;
         down_sat_q   <= down_sat_d;
      end
   end

   assign down_valid = down_valid_q;
   assign down_data  = down_data_q;
   assign down_sat   = down_sat_q;

endmodule

// File: tb/tb_signed_sat_accumulator.sv
module tb_signed_sat_accumulator;

   localparam int W     = 4;
   localparam int ACC_W = 6;
   localparam int HI    = 31;
   localparam int LO    = -32;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             up_valid = 1'b0;
   logic             up_ready;
   logic [W-1:0]     up_data = '0;
   logic             up_last = 1'b0;
   logic             down_valid;
   logic             down_ready = 1'b0;
   logic [ACC_W-1:0] down_data;
   logic             down_sat;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: plain integer frame sum with clamping.
   int m_acc    = 0;
   int m_sticky = 0;
   int m_valid  = 0;
   int m_data   = 0;
   int m_sat    = 0;

   signed_sat_accumulator #(.W(W), .ACC_W(ACC_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .up_valid   (up_valid),
      .up_ready   (up_ready),
      .up_data    (up_data),
      .up_last    (up_last),
      .down_valid (down_valid),
      .down_ready (down_ready),
      .down_data  (down_data),
      .down_sat   (down_sat)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int dd();
      return int'($signed(down_data));
   endfunction

   task automatic model_reset();
      m_acc = 0; m_sticky = 0; m_valid = 0; m_data = 0; m_sat = 0;
   endtask

   // One clock: drive inputs, compare everything at the falling edge, advance
   // the model by the handshakes that will happen at the next rising edge.
   task automatic step(input int v, input int x, input int last, input int dr);
      int fire;
      int sum;
      int ovf;
      up_valid   = v[0];
      up_data    = x[W-1:0];
      up_last    = last[0];
      down_ready = dr[0];
      @(negedge clk);
      chk("up_ready",   int'(up_ready),   (m_valid == 0 || dr != 0) ? 1 : 0);
      chk("down_valid", int'(down_valid), m_valid);
      chk("down_data",  dd(),             m_data);
      chk("down_sat",   int'(down_sat),   m_sat);
      fire = (v != 0 && (m_valid == 0 || dr != 0)) ? 1 : 0;
      if (m_valid != 0 && dr != 0) m_valid = 0;
      if (fire != 0) begin
         sum = m_acc + x;
         ovf = (sum > HI || sum < LO) ? 1 : 0;
         if (sum > HI) sum = HI;
         if (sum < LO) sum = LO;
         if (last != 0) begin
            m_data   = sum;
            m_sat    = (m_sticky != 0 || ovf != 0) ? 1 : 0;
            m_valid  = 1;
            m_acc    = 0;
            m_sticky = 0;
         end else begin
            m_acc    = sum;
            m_sticky = (m_sticky != 0 || ovf != 0) ? 1 : 0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic frame(input int x, input int count);
      for (int i = 0; i < count; i++) step(1, x, (i == count - 1) ? 1 : 0, 1);
   endtask

   task automatic expect_out(input string tag, input int d, input int s);
      chk({tag, "_valid"}, int'(down_valid), 1);
      chk({tag, "_data"},  dd(),             d);
      chk({tag, "_sat"},   int'(down_sat),   s);
   endtask

   initial begin
      int x;
      int v;
      int last;
      int dr;

      // reset state
      #2;
      chk("rst_valid", int'(down_valid), 0);
      chk("rst_data",  dd(),             0);
      chk("rst_sat",   int'(down_sat),   0);
      chk("rst_ready", int'(up_ready),   1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 3, -2, 5 -> 6 one cycle after the last handshake
      step(1, 3, 0, 1);
      step(1, -2, 0, 1);
      step(1, 5, 1, 1);
      expect_out("sum6", 6, 0);
      step(0, 0, 0, 1);
      chk("sum6_drained", int'(down_valid), 0);
      chk("sum6_held", dd(), 6);

      frame(7, 8);
      expect_out("pos_clamp", 31, 1);
      frame(-8, 8);
      expect_out("neg_clamp", -32, 1);

      // clamp is not undone: 35 -> 31, then 31 - 8 = 23
      for (int i = 0; i < 5; i++) step(1, 7, 0, 1);
      step(1, -8, 1, 1);
      expect_out("no_undo", 23, 1);

      // stall: result 5 held while down_ready low, inputs ignored
      step(1, 2, 0, 1);
      step(1, 3, 1, 1);
      expect_out("stall_pre", 5, 0);
      for (int i = 0; i < 5; i++) begin
         step(1, 7, 1, 0);
         chk("stall_ready", int'(up_ready), 0);
         chk("stall_data", dd(), 5);
         chk("stall_sat", int'(down_sat), 0);
      end
      // accept and new single-sample frame together: no bubble
      step(1, -3, 1, 1);
      expect_out("no_gap", -3, 0);
      step(0, 0, 0, 1);

      // reset mid-frame after 4, 4
      step(1, 4, 0, 1);
      step(1, 4, 0, 1);
      rst_n = 1'b0;
      up_valid = 1'b0;
      #1;
      model_reset();
      chk("mid_rst_valid", int'(down_valid), 0);
      chk("mid_rst_data",  dd(),             0);
      chk("mid_rst_sat",   int'(down_sat),   0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      step(1, 1, 1, 1);
      expect_out("after_rst", 1, 0);

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         x    = int'($urandom_range(0, 15)) - 8;
         v    = ($urandom_range(0, 3) != 0) ? 1 : 0;
         last = ($urandom_range(0, 4) == 0) ? 1 : 0;
         dr   = ($urandom_range(0, 3) != 0) ? 1 : 0;
         step(v, x, last, dr);
      end
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
